// File: rtl/filter_sweep_ctrl.sv
// rtl/filter_sweep_ctrl.sv - test_delay sweep sequencer with per-pulse peak measurement
module filter_sweep_ctrl #(
    parameter int SIZE_DELAY       = 8,
    parameter int SIZE_FILTER_DATA = 12,
    parameter int DELAY_START      = 0,
    parameter int DELAY_STEP       = 1,
    parameter int NUM_STEPS        = 8,
    parameter int PULSES_PER_STEP  = 4,
    parameter int WINDOW_LEN       = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          overlay_en,
    input  logic [2:0]                    sel,
    input  logic [6*SIZE_FILTER_DATA-1:0] filt_data,
    output logic                          test_overlay,
    output logic                          test_rate,
    output logic [SIZE_DELAY-1:0]         test_delay,
    output logic                          busy,
    output logic                          done,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [7:0]                    res_step,
    output logic [7:0]                    res_pulse,
    output logic [SIZE_FILTER_DATA-1:0]   res_peak,
    output logic [9:0]                    res_peak_time
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_FIRE   = 3'd2,
        S_WINDOW = 3'd3,
        S_REPORT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [SIZE_DELAY-1:0] DELAY_START_V = SIZE_DELAY'(DELAY_START);
    localparam logic [SIZE_DELAY-1:0] DELAY_STEP_V  = SIZE_DELAY'(DELAY_STEP);
    localparam logic [7:0]            LAST_STEP     = 8'(NUM_STEPS - 1);
    localparam logic [7:0]            LAST_PULSE    = 8'(PULSES_PER_STEP - 1);
    localparam logic [9:0]            LAST_OFFSET   = 10'(WINDOW_LEN - 1);

    state_t                        state;
    state_t                        next_state;
    logic [2:0]                    sel_q;
    logic [7:0]                    step_cnt;
    logic [7:0]                    pulse_cnt;
    logic [9:0]                    offset;
    logic [SIZE_FILTER_DATA-1:0]   peak;
    logic [9:0]                    peak_time;
    logic [SIZE_FILTER_DATA-1:0]   sample;
    logic                          last_pulse;
    logic                          last_step;
    logic                          handshake;

    assign last_pulse = (pulse_cnt == LAST_PULSE);
    assign last_step  = (step_cnt == LAST_STEP);
    assign handshake  = (state == S_REPORT) && res_ready;

    // select the filter output captured at sweep start; codes 6 and 7 read as zero
    always_comb begin
        sample = '0;
        case (sel_q)
            3'd0:    sample = filt_data[0*SIZE_FILTER_DATA +: SIZE_FILTER_DATA];
            3'd1:    sample = filt_data[1*SIZE_FILTER_DATA +: SIZE_FILTER_DATA];
            3'd2:    sample = filt_data[2*SIZE_FILTER_DATA +: SIZE_FILTER_DATA];
            3'd3:    sample = filt_data[3*SIZE_FILTER_DATA +: SIZE_FILTER_DATA];
            3'd4:    sample = filt_data[4*SIZE_FILTER_DATA +: SIZE_FILTER_DATA];
            3'd5:    sample = filt_data[5*SIZE_FILTER_DATA +: SIZE_FILTER_DATA];
            default: sample = '0;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state logic; abort dominates every state, including a same-cycle start
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_ARM;
            S_ARM:    next_state = S_FIRE;
            S_FIRE:   next_state = S_WINDOW;
            S_WINDOW: if (offset == LAST_OFFSET) next_state = S_REPORT;
            S_REPORT: begin
                if (res_ready) begin
                    if (!last_pulse)     next_state = S_FIRE;
                    else if (!last_step) next_state = S_ARM;
                    else                 next_state = S_DONE;
                end
            end
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
        if (abort) next_state = S_IDLE;
    end

    // state-decoded outputs; the result fields come straight from held registers
    always_comb begin
        test_rate = (state == S_FIRE);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        res_valid = (state == S_REPORT);
    end

    assign res_step      = step_cnt;
    assign res_pulse     = pulse_cnt;
    assign res_peak      = peak;
    assign res_peak_time = peak_time;

    // sweep configuration, stimulus controls, counters and peak tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q        <= '0;
            test_overlay <= 1'b0;
            test_delay   <= DELAY_START_V;
            step_cnt     <= '0;
            pulse_cnt    <= '0;
            offset       <= '0;
            peak         <= '0;
            peak_time    <= '0;
        end else if (abort) begin
            // test_delay intentionally holds so the generator is not disturbed
            test_overlay <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sel_q        <= sel;
                        test_overlay <= overlay_en;
                        test_delay   <= DELAY_START_V;
                        step_cnt     <= '0;
                        pulse_cnt    <= '0;
                    end
                end
                S_FIRE: begin
                    offset    <= '0;
                    peak      <= '0;
                    peak_time <= '0;
                end
                S_WINDOW: begin
                    offset <= offset + 10'd1;
                    // strict compare keeps the earliest occurrence of the maximum
                    if (sample > peak) begin
                        peak      <= sample;
                        peak_time <= offset;
                    end
                end
                S_REPORT: begin
                    if (handshake) begin
                        if (last_pulse) begin
                            pulse_cnt <= '0;
                            if (!last_step) begin
                                step_cnt   <= step_cnt + 8'd1;
                                test_delay <= test_delay + DELAY_STEP_V;
                            end
                        end else begin
                            pulse_cnt <= pulse_cnt + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    test_overlay <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_sweep_ctrl.sv
// tb/tb_filter_sweep_ctrl.sv - scoreboard bench for filter_sweep_ctrl
module tb_filter_sweep_ctrl;

    localparam int SD  = 8;
    localparam int SF  = 8;
    localparam int DS  = 250;
    localparam int DST = 4;
    localparam int NS  = 3;
    localparam int PP  = 2;
    localparam int WL  = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            overlay_en = 1'b0;
    logic [2:0]      sel = 3'd0;
    logic [6*SF-1:0] filt_data = '0;
    logic            test_overlay;
    logic            test_rate;
    logic [SD-1:0]   test_delay;
    logic            busy;
    logic            done;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [7:0]      res_step;
    logic [7:0]      res_pulse;
    logic [SF-1:0]   res_peak;
    logic [9:0]      res_peak_time;

    filter_sweep_ctrl #(
        .SIZE_DELAY(SD), .SIZE_FILTER_DATA(SF), .DELAY_START(DS), .DELAY_STEP(DST),
        .NUM_STEPS(NS), .PULSES_PER_STEP(PP), .WINDOW_LEN(WL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .overlay_en(overlay_en),
        .sel(sel), .filt_data(filt_data), .test_overlay(test_overlay), .test_rate(test_rate),
        .test_delay(test_delay), .busy(busy), .done(done), .res_valid(res_valid),
        .res_ready(res_ready), .res_step(res_step), .res_pulse(res_pulse),
        .res_peak(res_peak), .res_peak_time(res_peak_time)
    );

    always #5 clk = ~clk;

    typedef struct {
        int step;
        int pulse;
        int peak;
        int ptime;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   n_res = 0;
    int   pidx = 0;
    int   cur_sel = 0;
    bit   cur_ovl = 0;
    int   pat_mode = 0;
    int   ready_mode = 0;
    bit   skip_stab = 0;
    int   last_rate_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // done pulse counter
    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
    end

    // stimulus: on each rate pulse, build a window pattern, predict the result, drive it
    initial forever begin
        int pat[WL];
        exp_t e;
        int st, pu;
        @(negedge clk);
        if (test_rate && !reset) begin
            st = pidx / PP;
            pu = pidx % PP;
            chk("delay_at_rate", 32'(test_delay), 32'((DS + st * DST) % (1 << SD)));
            chk("overlay_at_rate", 32'(test_overlay), 32'(cur_ovl));
            if (ready_mode == 0 && pu > 0)
                chk("rate_spacing", 32'(cyc - last_rate_cyc), 32'(WL + 2));
            last_rate_cyc = cyc;
            for (int k = 0; k < WL; k++) begin
                if (pat_mode == 0) pat[k] = (k < 10) ? k : ((k == 10) ? 9 : 19 - k);
                else               pat[k] = $urandom_range(0, 15);
            end
            e.step = st; e.pulse = pu; e.peak = 0; e.ptime = 0;
            if (cur_sel < 6) begin
                for (int k = 0; k < WL; k++)
                    if (pat[k] > e.peak) begin e.peak = pat[k]; e.ptime = k; end
            end
            exp_q.push_back(e);
            pidx++;
            for (int k = 0; k < WL; k++) begin
                @(negedge clk);
                for (int ch = 0; ch < 6; ch++)
                    filt_data[ch*SF +: SF] = (ch == cur_sel) ? SF'(pat[k]) : SF'($urandom);
            end
        end
    end

    // monitor: drives res_ready, checks stability under back-pressure and pops on handshake
    initial begin
        bit            prev_stall = 0;
        bit            stalled_once = 0;
        int            stall_left = 0;
        logic [7:0]    ps, pp;
        logic [SF-1:0] pk;
        logic [9:0]    pt;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (ready_mode != 2) stalled_once = 0;
            if (prev_stall && !skip_stab && !reset) begin
                chk("stall_valid", 32'(res_valid), 1);
                chk("stall_fields", {res_step, res_pulse, 6'd0, res_peak, res_peak_time},
                    {ps, pp, 6'd0, pk, pt});
            end
            case (ready_mode)
                0: res_ready = 1'b1;
                1: res_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (res_valid && !stalled_once) begin
                        stall_left = 20;
                        stalled_once = 1;
                    end
                    if (stall_left > 0) begin
                        res_ready = 1'b0;
                        stall_left--;
                        chk("no_rate_in_stall", 32'(test_rate), 0);
                    end else begin
                        res_ready = 1'b1;
                    end
                end
                default: res_ready = 1'b0;
            endcase
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    n_res++;
                    chk("res_step", 32'(res_step), 32'(e.step));
                    chk("res_pulse", 32'(res_pulse), 32'(e.pulse));
                    chk("res_peak", 32'(res_peak), 32'(e.peak));
                    chk("res_peak_time", 32'(res_peak_time), 32'(e.ptime));
                end
            end
            prev_stall = res_valid && !res_ready;
            ps = res_step; pp = res_pulse; pk = res_peak; pt = res_peak_time;
        end
    end

    task automatic launch(input logic [2:0] s, input logic ovl);
        sel = s; overlay_en = ovl;
        cur_sel = int'(s); cur_ovl = ovl;
        pidx = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sel = 3'($urandom);
        overlay_en = ~ovl;
    endtask

    task automatic do_sweep(input logic [2:0] s, input logic ovl, input int rmode);
        int  busy_cyc = 0;
        int  d0 = done_cnt;
        int  r0 = n_res;
        bit  seen = 0;
        ready_mode = rmode;
        launch(s, ovl);
        for (int i = 0; i < 3000; i++) begin
            if (busy) busy_cyc++;
            if (i == 40) begin start = 1'b1; @(negedge clk); start = 1'b0; busy_cyc++; end
            if (done) begin seen = 1; break; end
            @(negedge clk);
        end
        chk("sweep_done_seen", 32'(seen), 1);
        if (rmode == 0) chk("sweep_busy_cycles", 32'(busy_cyc), 32'(NS * (1 + PP * (WL + 2)) + 1));
        @(negedge clk);
        chk("done_once", 32'(done_cnt - d0), 1);
        chk("results_count", 32'(n_res - r0), 32'(NS * PP));
        chk("queue_empty", 32'(exp_q.size()), 0);
        chk("idle_after", 32'(busy), 0);
        chk("overlay_cleared", 32'(test_overlay), 0);
        chk("delay_kept", 32'(test_delay), 32'((DS + (NS - 1) * DST) % (1 << SD)));
    endtask

    initial begin
        int d0;
        bit seen;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_delay", 32'(test_delay), DS);
        chk("rst_outputs", {test_overlay, test_rate, busy, done, res_valid}, 0);
        chk("rst_fields", {res_step, res_pulse, 6'd0, res_peak, res_peak_time}, 0);

        do_sweep(3'd2, 1'b1, 0);
        pat_mode = 1;
        do_sweep(3'($urandom_range(0, 5)), 1'b1, 2);
        do_sweep(3'($urandom_range(0, 5)), 1'b0, 1);
        do_sweep(3'd7, 1'b1, 0);

        // abort while a result is pending
        skip_stab = 1;
        d0 = done_cnt;
        launch(3'd1, 1'b1);
        ready_mode = 3;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (res_valid) begin seen = 1; break; end
            @(negedge clk);
        end
        chk("abort_valid_seen", 32'(seen), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_outputs", {test_overlay, test_rate, busy, done, res_valid}, 0);
        chk("abort_delay_held", 32'(test_delay), DS);
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        exp_q.delete();

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 0);
        @(negedge clk);
        chk("start_abort_idle2", 32'(busy), 0);

        // reset in the middle of a window
        ready_mode = 0;
        launch(3'd0, 1'b1);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (test_rate) begin seen = 1; break; end
            @(negedge clk);
        end
        chk("rate_before_reset", 32'(seen), 1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", {test_overlay, test_rate, busy, done, res_valid}, 0);
        chk("midrst_delay", 32'(test_delay), DS);
        chk("midrst_fields", {res_step, res_pulse, 6'd0, res_peak, res_peak_time}, 0);
        reset = 1'b0;
        repeat (WL + 2) @(negedge clk);
        chk("midrst_stay_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
